// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding, default width and counter sizing for the Booth multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
    localparam int MULT_WIDTH = 8;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration, add/sub of sext(M) into H then arithmetic shift of {H,Q,q_m1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   h,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   h_nx,
    output logic [WIDTH-1:0] q_nx,
    output logic             q_m1_nx
);
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;
    always_comb begin
        m_ext = {m[WIDTH-1], m};
        sum = (q[0] & ~q_m1) ? h - m_ext : (~q[0] & q_m1) ? h + m_ext : h;
        {h_nx, q_nx, q_m1_nx} = {sum[WIDTH], sum, q};
    end
endmodule

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential signed radix-2 Booth multiplier, one bit per cycle,
// full 2*WIDTH product with a one-cycle done strobe.
module booth_multiplier_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] R,
    output logic                      sign
);
    localparam int CW = cnt_width(WIDTH);
    mult_state_t    state;
    logic [WIDTH:0]   h, h_nx;
    logic [WIDTH-1:0] q, q_nx, m;
    logic             q_m1, q_m1_nx;
    logic [CW-1:0]    cnt;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .h(h), .q(q), .q_m1(q_m1), .m(m),
        .h_nx(h_nx), .q_nx(q_nx), .q_m1_nx(q_m1_nx)
    );

    // R/sign are loaded on the last RUN edge so they are valid during the DONE cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            R     <= '0;
            sign  <= 1'b0;
            h     <= '0;
            q     <= '0;
            m     <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    m     <= A;
                    q     <= B;
                    h     <= '0;
                    q_m1  <= 1'b0;
                    cnt   <= CW'(WIDTH);
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    h    <= h_nx;
                    q    <= q_nx;
                    q_m1 <= q_m1_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        R     <= {h_nx[WIDTH-1:0], q_nx};
                        sign  <= h_nx[WIDTH-1];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: directed and random products scored against plain integer multiplication.
module tb_booth_multiplier_seq;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic signed [W-1:0] A = '0;
    logic signed [W-1:0] B = '0;
    logic busy, done, sign;
    logic signed [2*W-1:0] R;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ops = 0;
    int done_cnt = 0;
    logic signed [2*W-1:0] exp_q[$];
    int acc_q[$];

    booth_multiplier_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .R(R), .sign(sign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: records accepted starts and scores every done against the queued product
    always @(negedge clk) begin
        if (rst_n && start && !busy) acc_q.push_back(cyc + 1);
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_done", R, 0);
            end else begin
                logic signed [2*W-1:0] e;
                e = exp_q.pop_front();
                chk(R == e, "product", R, e);
                chk(sign == (e < 0), "sign", sign, e < 0);
                if (acc_q.size() != 0) begin
                    int t;
                    t = acc_q.pop_front();
                    chk(cyc - t == W, "latency", cyc - t, W);
                end
            end
        end
    end

    // Issues one op at posedge+1 in IDLE; returns at posedge+1 in IDLE after DONE.
    task automatic do_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input bit extra);
        int n;
        logic signed [2*W-1:0] e;
        e = 16'(int'(a) * int'(b));
        A = a;
        B = b;
        start = 1'b1;
        exp_q.push_back(e);
        ops++;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        n = 0;
        while (!done && n < 40) begin
            start = extra;
            @(posedge clk); #1;
            A = W'($urandom);
            B = W'($urandom);
            n++;
        end
        chk(done, "done_timeout", done, 1);
        start = extra;
        @(posedge clk); #1;
        start = 1'b0;
        chk(R == e, "r_hold", R, e);
        chk(!busy && !done, "idle_after", {busy, done}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk(R == 0 && !sign, "reset_r", R, 0);
        chk(!busy && !done, "reset_ctl", {busy, done}, 0);
        rst_n = 1'b1;
        do_op(7, -3, 1'b0);
        chk(sign == 1'b1, "basic_sign", sign, 1);
        do_op(-128, -128, 1'b0);
        do_op(-128, 127, 1'b0);
        do_op(127, 127, 1'b0);
        do_op(0, -55, 1'b0);
        do_op(100, 3, 1'b1);
        do_op(-5, 6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == ops, "done_count", done_cnt, ops);
        // abort an op four cycles into RUN
        A = 9;
        B = 9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk(R == 0 && !sign, "midrst_r", R, 0);
        chk(!busy && !done, "midrst_ctl", {busy, done}, 0);
        rst_n = 1'b1;
        acc_q.delete();
        repeat (12) @(posedge clk);
        #1;
        chk(done_cnt == ops, "no_done_abort", done_cnt, ops);
        do_op(12, 11, 1'b0);
        for (int i = 0; i < 2000; i++) do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == ops, "final_count", done_cnt, ops);
        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
